// File: rtl/viterbi_channel_bert.sv
// Channel impairment injector and reference-bit BERT that sits between the
// convolutional encoder and the Viterbi decoder.
module viterbi_channel_bert #(
  parameter int SYM_W     = 2,
  parameter int PERIOD_W  = 4,
  parameter int REF_DEPTH = 32,
  parameter int CNT_W     = 16,
  parameter int WINDOW    = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode_i,
  input  logic [SYM_W-1:0]    flip_mask_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [2:0]          burst_len_i,
  input  logic [7:0]          lfsr_thresh_i,
  input  logic                start_i,
  input  logic                sym_valid_i,
  input  logic [SYM_W-1:0]    sym_i,
  input  logic                ref_bit_i,
  output logic                sym_valid_o,
  output logic [SYM_W-1:0]    sym_o,
  output logic [SYM_W-1:0]    err_inj_o,
  input  logic                dec_valid_i,
  input  logic                dec_bit_i,
  output logic [CNT_W-1:0]    chan_err_ct_o,
  output logic [CNT_W-1:0]    dec_err_ct_o,
  output logic [CNT_W-1:0]    word_ct_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                align_err_o
);

  localparam int          AW      = $clog2(REF_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [31:0] WIN     = 32'(WINDOW);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state;
  logic [PERIOD_W-1:0] r_pcnt;
  logic [2:0]          r_burst;
  logic [15:0]         r_lfsr;
  logic                r_sym_valid;
  logic [SYM_W-1:0]    r_sym;
  logic [SYM_W-1:0]    r_inj;
  logic                r_mem [REF_DEPTH];
  logic [AW:0]         r_wp;
  logic [AW:0]         r_rp;
  logic [CNT_W-1:0]    r_chan;
  logic [CNT_W-1:0]    r_dec;
  logic [CNT_W-1:0]    r_word;
  logic                r_busy;
  logic                r_done;
  logic                r_align;

  logic                w_phit;
  logic                w_hit;
  logic [2:0]          w_blen;
  logic                w_fb;
  logic [SYM_W-1:0]    w_mask;
  logic [CNT_W-1:0]    w_flips;
  logic                w_empty;
  logic                w_full;
  logic                w_bypass;
  logic                w_pop;
  logic                w_push;
  logic                w_cmp;
  logic                w_head;
  logic                w_ovf;
  logic                w_udf;
  logic [CNT_W:0]      w_chan_sum;
  logic [CNT_W-1:0]    w_chan_nx;
  logic [CNT_W-1:0]    w_word_nx;
  logic [CNT_W-1:0]    w_dec_nx;
  logic                w_reach;

  assign w_phit = (r_pcnt == period_i);
  assign w_blen = (burst_len_i == 3'd0) ? 3'd1 : burst_len_i;
  assign w_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_comb begin
    w_hit = 1'b0;
    unique case (mode_i)
      2'b01:   w_hit = w_phit;
      2'b10:   w_hit = (r_lfsr[7:0] < lfsr_thresh_i);
      2'b11:   w_hit = w_phit || (r_burst != 3'd0);
      default: w_hit = 1'b0;
    endcase
  end

  assign w_mask = (sym_valid_i && w_hit) ? flip_mask_i : '0;

  always_comb begin
    w_flips = '0;
    for (int unsigned i = 0; i < SYM_W; i++) w_flips = w_flips + CNT_W'(w_mask[i]);
  end

  // Period counter and LFSR advance on every valid symbol regardless of mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pcnt      <= '0;
      r_burst     <= '0;
      r_lfsr      <= 16'hACE1;
      r_sym_valid <= 1'b0;
      r_sym       <= '0;
      r_inj       <= '0;
    end else begin
      r_sym_valid <= sym_valid_i;
      r_inj       <= w_mask;
      if (sym_valid_i) begin
        r_sym  <= sym_i ^ w_mask;
        r_pcnt <= w_phit ? '0 : r_pcnt + PERIOD_W'(1);
        r_lfsr <= {r_lfsr[14:0], w_fb};
        if (mode_i == 2'b11)
          r_burst <= w_phit ? (w_blen - 3'd1) : ((r_burst != 3'd0) ? r_burst - 3'd1 : 3'd0);
      end
    end
  end

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  // An empty FIFO with a simultaneous push compares against the incoming bit.
  assign w_bypass = dec_valid_i && w_empty && sym_valid_i;
  assign w_pop    = dec_valid_i && !w_empty;
  assign w_cmp    = w_pop || w_bypass;
  assign w_head   = w_empty ? ref_bit_i : r_mem[r_rp[AW-1:0]];
  assign w_push   = sym_valid_i && !w_bypass && (!w_full || w_pop);
  assign w_ovf    = sym_valid_i && w_full && !dec_valid_i;
  assign w_udf    = dec_valid_i && w_empty && !sym_valid_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PTR_ONE;
      if (w_pop)  r_rp <= r_rp + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= ref_bit_i;
  end

  assign w_chan_sum = {1'b0, r_chan} + {1'b0, w_flips};
  assign w_chan_nx  = w_chan_sum[CNT_W] ? '1 : w_chan_sum[CNT_W-1:0];
  assign w_word_nx  = (&r_word) ? r_word : r_word + CNT_W'(1);
  assign w_dec_nx   = ((w_head != dec_bit_i) && !(&r_dec)) ? r_dec + CNT_W'(1) : r_dec;
  assign w_reach    = (32'(r_word) + 32'd1) == WIN;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_chan  <= '0;
      r_dec   <= '0;
      r_word  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_align <= 1'b0;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (sym_valid_i) r_chan <= w_chan_nx;
          if (w_cmp) begin
            r_word <= w_word_nx;
            r_dec  <= w_dec_nx;
            if (w_reach) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          if (start_i) begin
            r_state <= S_RUN;
            r_chan  <= '0;
            r_dec   <= '0;
            r_word  <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_align <= 1'b0;
          end
        end
      endcase
      if (w_ovf || w_udf) r_align <= 1'b1;
    end
  end

  assign sym_valid_o   = r_sym_valid;
  assign sym_o         = r_sym;
  assign err_inj_o     = r_inj;
  assign chan_err_ct_o = r_chan;
  assign dec_err_ct_o  = r_dec;
  assign word_ct_o     = r_word;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign align_err_o   = r_align;

endmodule

// File: doc/viterbi_channel_bert.md
Name: viterbi_channel_bert

Overview:
Parametrised channel-impairment and bit-error-rate checker for the convolutional encoder / Viterbi decoder loop. It sits between encoder and decoder:
- Registers coded symbols and flips selected bits according to a programmable error mode (clean, periodic, pseudo-random, burst).
- Queues the uncoded reference bits and compares them against decoder output.
- Counts channel and post-decode errors over a measurement window.

Parameters:
SYM_W, 2, bits per coded symbol.
PERIOD_W, 4, width of period counter and period_i.
REF_DEPTH, 32, reference-bit FIFO depth (power of 2, at least decoder latency + 2).
CNT_W, 16, width of all statistic counters.
WINDOW, 256, decoded bits per measurement window.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
mode_i  in  2  00 clean, 01 periodic, 10 LFSR, 11 burst
flip_mask_i  in  SYM_W  bits to invert on an injected symbol
period_i  in  PERIOD_W  injection period minus 1
burst_len_i  in  3  burst length in symbols (0 treated as 1)
lfsr_thresh_i  in  8  inject when lfsr[7:0] < threshold
start_i  in  1  start measurement window (pulse)
sym_valid_i  in  1  encoder symbol valid
sym_i  in  SYM_W  encoder symbol
ref_bit_i  in  1  uncoded encoder input bit, qualified by sym_valid_i
sym_valid_o  out  1  symbol valid to decoder
sym_o  out  SYM_W  possibly corrupted symbol to decoder
err_inj_o  out  SYM_W  mask applied to sym_o this cycle
dec_valid_i  in  1  decoder output valid
dec_bit_i  in  1  decoded bit
chan_err_ct_o  out  CNT_W  flipped channel bits in window
dec_err_ct_o  out  CNT_W  decoded-bit mismatches in window
word_ct_o  out  CNT_W  decoded bits compared in window
busy_o  out  1  window in progress
done_o  out  1  window complete (level, held until next start)
align_err_o  out  1  sticky: FIFO overflow or underflow

Behaviour:
- Reset (rst low, asynchronous): all outputs 0; FSM in IDLE; period counter 0; burst remaining 0; LFSR = 16'hACE1; FIFO empty.
- Channel path, 1-cycle latency:
  - sym_valid_o = registered sym_valid_i.
  - sym_o = registered sym_i XOR inject_mask.
  - err_inj_o = registered inject_mask.
  - When sym_valid_i = 0: sym_valid_o = 0, sym_o holds, err_inj_o = 0.
- Injection is active in every FSM state. inject_mask = flip_mask_i when the mode hit is true, else 0. Mode hits are evaluated only on sym_valid_i:
  - 00: never.
  - 01: hit when period counter == period_i. Period counter increments per valid symbol and wraps to 0 after reaching period_i, so period_i = 3 hits symbols 3, 7, 11, ...
  - 10: hit when lfsr[7:0] < lfsr_thresh_i. The LFSR is Fibonacci x^16+x^14+x^13+x^11+1, shifting left once per valid symbol after evaluation. Threshold 0 never hits.
  - 11: a periodic hit loads burst remaining = max(burst_len_i, 1). Hit while remaining > 0; decrement per valid symbol. A periodic hit during an active burst reloads the count.
- Mode change takes effect on the next valid symbol; the period counter is not cleared.
- Reference FIFO:
  - Push ref_bit_i on sym_valid_i; pop on dec_valid_i.
  - Simultaneous push and pop allowed at any occupancy, including full and empty.
  - Push when full and not popping: bit dropped, align_err_o set.
  - Pop when empty: no compare, align_err_o set.
  - align_err_o is cleared only by reset or start_i.
- FSM states IDLE, RUN, DONE:
  - IDLE/DONE with start_i -> RUN: clear the three counters, done_o and align_err_o (FIFO contents kept); busy_o = 1.
  - RUN: on each dec_valid_i with FIFO non-empty:
    - word_ct += 1.
    - dec_err_ct += (dec_bit_i != FIFO head).
    - chan_err_ct += popcount(inject_mask) for every valid input symbol.
  - RUN when word_ct reaches WINDOW -> DONE: busy_o = 0, done_o = 1; counters freeze.
  - start_i during RUN is ignored.
- Counters saturate at all-ones and never wrap.
- Counter updates occur only in RUN; a symbol arriving in the same cycle as start_i is not counted.
- Reset mid-window returns to IDLE with everything cleared.

Test Plan:
1. mode 00, start, 300 symbols, decoder loopback of ref bits delayed 6 cycles -> done_o after 256 compares; word_ct = 256, dec_err_ct = 0, chan_err_ct = 0, align_err_o = 0.
2. mode 01, period_i = 3, flip_mask 01, sym_i = 00 constant -> sym_o = 01 on every 4th valid symbol, 00 otherwise; chan_err_ct = 64 after 256 symbols.
3. mode 11, period_i = 7, burst_len 3, mask 11 -> symbols 7, 8, 9 then 15, 16, 17 corrupted to 11; chan_err_ct increments by 2 per corrupted symbol.
4. mode 10, threshold 0 -> zero injections; threshold 255 -> all symbols except those with lfsr[7:0] = FF flipped; first LFSR hit check uses seed ACE1 (E1 < thresh).
5. dec_valid_i pulses with FIFO empty, then 33 pushes without pops (REF_DEPTH 32) -> align_err_o = 1, no compare; start_i clears it.
6. Reset asserted mid-RUN at word_ct = 100 -> all outputs 0 immediately; start_i in RUN ignored; saturation forced with CNT_W = 4 holds chan_err_ct at 15.
